// File: rtl/vga_pkg.sv
// Shared VGA timing presets, pipeline bundle and colour-bar helpers
// for the vga_timing_ctrl slice.
package vga_pkg;

  typedef struct packed {
    int h_sync;
    int h_bp;
    int h_active;
    int h_fp;
    int v_sync;
    int v_bp;
    int v_active;
    int v_fp;
    bit h_pol;
    bit v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_sync: 96, h_bp: 48, h_active: 640, h_fp: 16,
    v_sync: 2, v_bp: 33, v_active: 480, v_fp: 10,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam vga_mode_t MODE_800X600 = '{
    h_sync: 128, h_bp: 88, h_active: 800, h_fp: 40,
    v_sync: 4, v_bp: 23, v_active: 600, v_fp: 1,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam vga_mode_t MODE_1024X768 = '{
    h_sync: 136, h_bp: 160, h_active: 1024, h_fp: 24,
    v_sync: 6, v_bp: 29, v_active: 768, v_fp: 3,
    h_pol: 1'b0, v_pol: 1'b0
  };

  // Per-counter-state flags carried down the alignment pipe
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic first;
  } tim_t;

  // Bar codes are {b,g,r}; each bit fans out to a full field
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b011;
  localparam logic [2:0] BAR_CYAN    = 3'b110;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b001;
  localparam logic [2:0] BAR_BLUE    = 3'b100;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_code(
    input logic [2:0] idx
  );
    logic [2:0] c;
    c = BAR_BLACK;
    case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Frame-buffer request/data side and DAC pin side of vga_timing_ctrl.
// master = controller, slave = requester/DAC model.
interface vga_timing_ctrl_if #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
);
  localparam int PIX_W = R_W + G_W + B_W;

  logic             data_req;
  logic             req_frame_start;
  logic [PIX_W-1:0] din;
  logic             din_valid;
  logic             frame_start;
  logic             vga_hsync;
  logic             vga_vsync;
  logic             vga_de;
  logic [R_W-1:0]   vga_red;
  logic [G_W-1:0]   vga_green;
  logic [B_W-1:0]   vga_blue;
  logic             underflow;

  modport master (
    input  din, din_valid,
    output data_req, req_frame_start,
    output frame_start, vga_hsync, vga_vsync,
    output vga_de, vga_red, vga_green, vga_blue,
    output underflow
  );

  modport slave (
    output din, din_valid,
    input  data_req, req_frame_start,
    input  frame_start, vga_hsync, vga_vsync,
    input  vga_de, vga_red, vga_green, vga_blue,
    input  underflow
  );

endinterface

// File: rtl/vga_pattern_gen.sv
// Eight vertical colour bars from the aligned active x index.
// Only instantiated when VGA_TEST_PATTERN_EN is defined.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int XW       = 11,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
) (
  input  logic [XW-1:0]            x,
  output logic [R_W+G_W+B_W-1:0]   rgb
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  int         bar;
  logic [2:0] code;

  always_comb begin
    bar = int'(x) / BAR_W;
    if (bar > 7) bar = 7;
    code = bar_code(3'(bar));
    rgb = {{B_W{code[2]}}, {G_W{code[1]}}, {R_W{code[0]}}};
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA timing with latency-aligned pixel fetch and underflow.
// Optional colour-bar source under `define VGA_TEST_PATTERN_EN.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int REQ_LAT  = 2
) (
  input logic clk,
  input logic rst,
  input logic en,
`ifdef VGA_TEST_PATTERN_EN
  input logic pattern_sel,
`endif
  vga_timing_ctrl_if.master bus
);

  localparam int H_TOT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW     = clog2(H_TOT);
  localparam int VW     = clog2(V_TOT);
  localparam int PIX_W  = R_W + G_W + B_W;
  localparam int H_ACT0 = H_SYNC + H_BP;
  localparam int V_ACT0 = V_SYNC + V_BP;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = h_cnt == HW'(H_TOT - 1);
  assign v_last = v_cnt == VW'(V_TOT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  tim_t cur;
  logic first_px;
  logic h_in;
  logic v_in;

  always_comb begin
    h_in = (int'(h_cnt) >= H_ACT0)
        && (int'(h_cnt) < H_ACT0 + H_ACTIVE);
    v_in = (int'(v_cnt) >= V_ACT0)
        && (int'(v_cnt) < V_ACT0 + V_ACTIVE);
    cur       = '0;
    cur.hs    = int'(h_cnt) < H_SYNC;
    cur.vs    = int'(v_cnt) < V_SYNC;
    cur.act   = h_in && v_in;
    cur.first = (h_cnt == '0) && (v_cnt == '0);
    first_px  = (int'(h_cnt) == H_ACT0)
             && (int'(v_cnt) == V_ACT0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_req        <= 1'b0;
      bus.req_frame_start <= 1'b0;
    end else if (!en) begin
      bus.data_req        <= 1'b0;
      bus.req_frame_start <= 1'b0;
    end else begin
      bus.data_req        <= cur.act;
      bus.req_frame_start <= cur.act & first_px;
    end
  end

  // Tail entry lines up with the cycle the requester returns din
  tim_t [REQ_LAT:0] pipe;
  tim_t             tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (!en) begin
      pipe <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i <= REQ_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[REQ_LAT];

  logic             pix_ok;
  logic [PIX_W-1:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0]    x_cur;
  logic [HW-1:0]    x_pipe [REQ_LAT+1];
  logic [PIX_W-1:0] pat;

  assign x_cur = h_cnt - HW'(H_ACT0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= REQ_LAT; i++)
        x_pipe[i] <= '0;
    end else begin
      x_pipe[0] <= x_cur;
      for (int i = 1; i <= REQ_LAT; i++)
        x_pipe[i] <= x_pipe[i-1];
    end
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (HW),
    .R_W      (R_W),
    .G_W      (G_W),
    .B_W      (B_W)
  ) u_pattern (
    .x   (x_pipe[REQ_LAT]),
    .rgb (pat)
  );

  assign pix_ok = pattern_sel | bus.din_valid;
  assign pix    = pattern_sel ? pat : bus.din;
`else
  assign pix_ok = bus.din_valid;
  assign pix    = bus.din;
`endif

  logic uf_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_hsync   <= ~H_POL;
      bus.vga_vsync   <= ~V_POL;
      bus.vga_de      <= 1'b0;
      bus.frame_start <= 1'b0;
      uf_pix          <= 1'b0;
      {bus.vga_blue, bus.vga_green, bus.vga_red} <= '0;
    end else if (!en) begin
      bus.vga_hsync   <= ~H_POL;
      bus.vga_vsync   <= ~V_POL;
      bus.vga_de      <= 1'b0;
      bus.frame_start <= 1'b0;
      uf_pix          <= 1'b0;
      {bus.vga_blue, bus.vga_green, bus.vga_red} <= '0;
    end else begin
      bus.vga_hsync   <= tail.hs ? H_POL : ~H_POL;
      bus.vga_vsync   <= tail.vs ? V_POL : ~V_POL;
      bus.vga_de      <= tail.act;
      bus.frame_start <= tail.first;
      uf_pix          <= tail.act & ~pix_ok;
      {bus.vga_blue, bus.vga_green, bus.vga_red} <=
        (tail.act && pix_ok) ? pix : '0;
    end
  end

  // A missing pixel in the frame_start cycle outranks the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.underflow <= 1'b0;
    else if (uf_pix)
      bus.underflow <= 1'b1;
    else if (bus.frame_start)
      bus.underflow <= 1'b0;
  end

endmodule
